// File: rtl/accel_if.sv
// Accelerator bus between the CPU's WACC/RACC datapath (master) and an accelerator (slave).
interface accel_if #(
    parameter int WIDTH = 16
);
    logic             accel_can_write;
    logic             accel_write_enable;
    logic [WIDTH-1:0] accel_write_data;
    logic             accel_can_read;
    logic             accel_read_enable;
    logic [WIDTH-1:0] accel_read_data;

    modport master (
        input  accel_can_write, accel_can_read, accel_read_data,
        output accel_write_enable, accel_write_data, accel_read_enable
    );

    modport slave (
        output accel_can_write, accel_can_read, accel_read_data,
        input  accel_write_enable, accel_write_data, accel_read_enable
    );
endinterface

// File: rtl/accel_divider.sv
// Iterative restoring divider on the accelerator bus: write dividend, divisor; read quotient, remainder.
// Define ACCEL_DIV_SIGNED_EN for two's-complement signed division (truncating toward zero).
module accel_divider #(
    parameter int WIDTH = 16
) (
    input  logic   clk,
    input  logic   rst,
    accel_if.slave bus,
    output logic   busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_A,
        S_B,
        S_BUSY,
        S_Q,
        S_R
`ifdef ACCEL_DIV_SIGNED_EN
        , S_FIX
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend, becomes the quotient as bits shift in
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_sub;
    logic             q_bit;

`ifdef ACCEL_DIV_SIGNED_EN
    logic [WIDTH-1:0] orig_q, orig_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction
`endif

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can infer a latch.
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
`ifdef ACCEL_DIV_SIGNED_EN
        orig_d    = orig_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif

        rem_shift = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        rem_sub   = rem_shift - {1'b0, dvs_q};
        q_bit     = (rem_shift >= {1'b0, dvs_q});

        case (state_q)
            S_A: begin
                if (bus.accel_write_enable) begin
                    dvd_d   = bus.accel_write_data;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (bus.accel_write_enable) begin
`ifdef ACCEL_DIV_SIGNED_EN
                    orig_d    = dvd_q;
                    neg_quo_d = dvd_q[WIDTH-1] ^ bus.accel_write_data[WIDTH-1];
                    neg_rem_d = dvd_q[WIDTH-1];
                    dvd_d     = magnitude(dvd_q);
                    dvs_d     = magnitude(bus.accel_write_data);
`else
                    dvs_d     = bus.accel_write_data;
`endif
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // A zero divisor needs no special case: every compare succeeds, giving
                // an all-ones quotient and the dividend as remainder.
                rem_d = q_bit ? rem_sub : rem_shift;
                dvd_d = {dvd_q[WIDTH-2:0], q_bit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef ACCEL_DIV_SIGNED_EN
                    state_d = S_FIX;
`else
                    rdata_d = {dvd_q[WIDTH-2:0], q_bit};
                    state_d = S_Q;
`endif
                end
            end
`ifdef ACCEL_DIV_SIGNED_EN
            S_FIX: begin
                if (dvs_q == '0) begin
                    rdata_d = '1;
                    rem_d   = {1'b0, orig_q};
                end else begin
                    rdata_d = neg_quo_q ? -dvd_q : dvd_q;
                    rem_d   = {1'b0, neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0]};
                end
                state_d = S_Q;
            end
`endif
            S_Q: begin
                if (bus.accel_read_enable) begin
                    rdata_d = rem_q[WIDTH-1:0];
                    state_d = S_R;
                end
            end
            S_R: begin
                if (bus.accel_read_enable) begin
                    rdata_d = '0;
                    state_d = S_A;
                end
            end
            default: state_d = S_A;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: operand/accumulator flops carry no reset; every path into S_Q reloads them first.
    always_ff @(posedge clk) begin
        dvd_q <= dvd_d;
        dvs_q <= dvs_d;
        rem_q <= rem_d;
`ifdef ACCEL_DIV_SIGNED_EN
        orig_q    <= orig_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
`endif
    end

    assign bus.accel_can_write = (state_q == S_A) || (state_q == S_B);
    assign bus.accel_can_read  = (state_q == S_Q) || (state_q == S_R);
    assign bus.accel_read_data = rdata_q;
`ifdef ACCEL_DIV_SIGNED_EN
    assign busy = (state_q == S_BUSY) || (state_q == S_FIX);
`else
    assign busy = (state_q == S_BUSY);
`endif
endmodule

// File: tb/tb_accel_divider.sv
// Directed bench for accel_divider: inputs driven and outputs sampled on the falling clock edge.
module tb_accel_divider;
    localparam int WIDTH = 16;
`ifdef ACCEL_DIV_SIGNED_EN
    localparam int LAT = WIDTH + 1;
`else
    localparam int LAT = WIDTH;
`endif
    localparam int TMO = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   checks = 0;
    int   failures = 0;

    accel_if #(.WIDTH(WIDTH)) bus ();

    accel_divider #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [WIDTH-1:0] d);
        int n = 0;
        while (!bus.accel_can_write && n < TMO) begin
            @(negedge clk);
            n++;
        end
        check("wr_ready", bus.accel_can_write, 1);
        bus.accel_write_enable = 1'b1;
        bus.accel_write_data   = d;
        @(negedge clk);
        bus.accel_write_enable = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [WIDTH-1:0] exp);
        int n = 0;
        while (!bus.accel_can_read && n < TMO) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, bus.accel_can_read, 1);
        check(tag, bus.accel_read_data, exp);
        bus.accel_read_enable = 1'b1;
        @(negedge clk);
        bus.accel_read_enable = 1'b0;
    endtask

    task automatic op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er);
        wr(a);
        wr(b);
        rd({tag, "_quo"}, eq);
        rd({tag, "_rem"}, er);
    endtask

    // Assumes read_enable is already held high; each result word must be visible for one cycle.
    task automatic b2b(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er);
        int n = 0;
        wr(a);
        wr(b);
        while (!bus.accel_can_read && n < TMO) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_q_ready"}, bus.accel_can_read, 1);
        check({tag, "_quo"}, bus.accel_read_data, eq);
        @(negedge clk);
        check({tag, "_r_ready"}, bus.accel_can_read, 1);
        check({tag, "_rem"}, bus.accel_read_data, er);
        @(negedge clk);
        check({tag, "_closed"}, bus.accel_can_read, 0);
        check({tag, "_can_write"}, bus.accel_can_write, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.accel_write_enable = 1'b0;
        bus.accel_write_data   = '0;
        bus.accel_read_enable  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_can_write", bus.accel_can_write, 1);
        check("rst_can_read", bus.accel_can_read, 0);
        check("rst_read_data", bus.accel_read_data, 0);
        check("rst_busy", busy, 0);

        // 100 / 7, with the busy window measured from the divisor write
        wr(16'd100);
        wr(16'd7);
        n = 0;
        while (busy && n < TMO) begin
            @(negedge clk);
            n++;
        end
        check("busy_cycles", n, LAT);
        check("done_can_read", bus.accel_can_read, 1);
        check("done_can_write", bus.accel_can_write, 0);
        rd("d100_7_quo", 16'd14);
        rd("d100_7_rem", 16'd2);
        check("after_can_write", bus.accel_can_write, 1);

        op("div0", 16'h1234, 16'h0000, 16'hFFFF, 16'h1234);

        // Stray read in S_A, stray writes in S_BUSY and S_Q
        bus.accel_read_enable = 1'b1;
        @(negedge clk);
        bus.accel_read_enable = 1'b0;
        check("ign_rd_can_write", bus.accel_can_write, 1);
        check("ign_rd_can_read", bus.accel_can_read, 0);
        wr(16'hFFFF);
        wr(16'h0001);
        bus.accel_write_enable = 1'b1;
        bus.accel_write_data   = 16'h5555;
        repeat (3) @(negedge clk);
        bus.accel_write_enable = 1'b0;
        check("ign_wr_busy", busy, 1);
        n = 0;
        while (!bus.accel_can_read && n < TMO) begin
            @(negedge clk);
            n++;
        end
        bus.accel_write_enable = 1'b1;
        bus.accel_write_data   = 16'hAAAA;
        @(negedge clk);
        bus.accel_write_enable = 1'b0;
        check("ign_wr_sq_can_read", bus.accel_can_read, 1);
        rd("ign_quo", 16'hFFFF);
        rd("ign_rem", 16'h0000);

        // Reset on the fifth busy cycle
        wr(16'd1000);
        wr(16'd3);
        repeat (4) @(negedge clk);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_can_write", bus.accel_can_write, 1);
        check("mid_rst_can_read", bus.accel_can_read, 0);
        check("mid_rst_read_data", bus.accel_read_data, 0);
        check("mid_rst_busy", busy, 0);
        op("d50_5", 16'd50, 16'd5, 16'd10, 16'd0);

        // Back-to-back with read_enable held high throughout
        bus.accel_read_enable = 1'b1;
`ifdef ACCEL_DIV_SIGNED_EN
        b2b("b2b_a", 16'hFFFF, 16'd256, 16'h0000, 16'hFFFF);
`else
        b2b("b2b_a", 16'hFFFF, 16'd256, 16'd255, 16'd255);
`endif
        b2b("b2b_b", 16'd9, 16'd10, 16'd0, 16'd9);
        bus.accel_read_enable = 1'b0;

`ifdef ACCEL_DIV_SIGNED_EN
        op("s_m7_2", 16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF);
        op("s_7_m2", 16'd7, 16'hFFFE, 16'hFFFD, 16'h0001);
        op("s_ovf", 16'h8000, 16'hFFFF, 16'h8000, 16'h0000);
        op("s_div0", 16'hFFF9, 16'h0000, 16'hFFFF, 16'hFFF9);
`else
        op("u_max", 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000);
        op("u_small", 16'd3, 16'd5, 16'd0, 16'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
